// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch-predictor update controller.
package bp_pkg;

   // 2-bit direction counter encodings
   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   typedef enum logic [1:0] {INIT, IDLE, S_BHT, S_PHT} upd_state_e;

   // Saturating counter step toward the resolved direction
   function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      nxt = ctr;
      unique case (ctr)
         SNT: nxt = taken ? WNT : SNT;
         WNT: nxt = taken ? WT  : SNT;
         WT:  nxt = taken ? ST  : WNT;
         ST:  nxt = taken ? ST  : WT;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Small synchronous FIFO for resolved-branch updates. A push while full is
// accepted when a pop happens in the same cycle.
module bp_upd_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 11
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [Width-1:0] wdata_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == (AW + 1)'(Depth));
   assign empty_o = (cnt_q == '0);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem_q[rd_ptr_q];

   // Storage array, no reset needed
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Pointers and occupancy
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (do_push && !do_pop) begin
            cnt_q <= cnt_q + (AW + 1)'(1);
         end else if (do_pop && !do_push) begin
            cnt_q <= cnt_q - (AW + 1)'(1);
         end
      end
   end

endmodule

// File: rtl/bp_update_ctrl.sv
// Local-history predictor update sequencer: post-reset table sweep, then one
// serialized BHT-read / PHT-read / write per queued branch outcome.
module bp_update_ctrl
   import bp_pkg::*;
#(
   parameter int unsigned BHT_DEPTH  = 10,
   parameter int unsigned PHT_DEPTH  = 6,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 upd_valid,
   input  logic [31:0]          upd_pc,
   input  logic                 upd_taken,
   output logic [BHT_DEPTH-1:0] bht_raddr,
   input  logic [PHT_DEPTH-1:0] bht_rdata,
   output logic [PHT_DEPTH-1:0] pht_raddr,
   input  logic [1:0]           pht_rdata,
   output logic                 bht_we,
   output logic [BHT_DEPTH-1:0] bht_waddr,
   output logic [PHT_DEPTH-1:0] bht_wdata,
   output logic                 pht_we,
   output logic [PHT_DEPTH-1:0] pht_waddr,
   output logic [1:0]           pht_wdata,
   output logic                 init_busy,
   output logic                 upd_drop,
   output logic [15:0]          drop_cnt
);

   localparam int unsigned EntryW = BHT_DEPTH + 1;

   upd_state_e           state_q, state_d;
   logic [BHT_DEPTH-1:0] idx_q, idx_d;
   logic [BHT_DEPTH-1:0] upd_idx_q;
   logic                 taken_q;
   logic [PHT_DEPTH-1:0] bhr_q;
   logic [BHT_DEPTH-1:0] bht_raddr_q;
   logic [PHT_DEPTH-1:0] pht_raddr_q;
   logic                 drop_q;
   logic [15:0]          drop_cnt_q;

   logic                 push, pop, drop, full, empty;
   logic [EntryW-1:0]    fifo_rdata;
   logic                 unused_pc;

   assign unused_pc = ^{upd_pc[31:BHT_DEPTH+2], upd_pc[1:0]};

   assign push      = upd_valid && (state_q != INIT);
   assign pop       = (state_q == IDLE) && !empty;
   assign drop      = push && full && !pop;
   assign init_busy = rst || (state_q == INIT);
   assign upd_drop  = drop_q;
   assign drop_cnt  = drop_cnt_q;

   bp_upd_fifo #(
      .Depth (FIFO_DEPTH),
      .Width (EntryW)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i ({upd_pc[BHT_DEPTH+1:2], upd_taken}),
      .rdata_o (fifo_rdata),
      .full_o  (full),
      .empty_o (empty)
   );

   // Next state, read addresses and table write strobes
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      bht_raddr = bht_raddr_q;
      pht_raddr = pht_raddr_q;
      bht_we    = 1'b0;
      bht_waddr = '0;
      bht_wdata = '0;
      pht_we    = 1'b0;
      pht_waddr = '0;
      pht_wdata = '0;
      unique case (state_q)
         INIT: begin
            bht_we    = 1'b1;
            bht_waddr = idx_q;
            pht_we    = ((idx_q >> PHT_DEPTH) == '0);
            pht_waddr = idx_q[PHT_DEPTH-1:0];
            pht_wdata = WT;
            idx_d     = idx_q + BHT_DEPTH'(1);
            if (idx_q == '1) state_d = IDLE;
         end
         IDLE: begin
            if (!empty) begin
               bht_raddr = fifo_rdata[EntryW-1:1];
               state_d   = S_BHT;
            end
         end
         S_BHT: begin
            pht_raddr = bht_rdata;
            state_d   = S_PHT;
         end
         S_PHT: begin
            bht_we    = 1'b1;
            bht_waddr = upd_idx_q;
            bht_wdata = {bhr_q[PHT_DEPTH-2:0], taken_q};
            pht_we    = 1'b1;
            pht_waddr = bhr_q;
            pht_wdata = ctr_next(pht_rdata, taken_q);
            state_d   = IDLE;
         end
      endcase
      // Reset kills any write in flight, including the INIT sweep
      if (rst) begin
         bht_we = 1'b0;
         pht_we = 1'b0;
      end
   end

   // State, latched update context and drop bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= INIT;
         idx_q       <= '0;
         upd_idx_q   <= '0;
         taken_q     <= 1'b0;
         bhr_q       <= '0;
         bht_raddr_q <= '0;
         pht_raddr_q <= '0;
         drop_q      <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         bht_raddr_q <= bht_raddr;
         pht_raddr_q <= pht_raddr;
         if (pop) {upd_idx_q, taken_q} <= fifo_rdata;
         if (state_q == S_BHT) bhr_q <= bht_rdata;
         drop_q <= drop;
         if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed bench for bp_update_ctrl with behavioural synchronous-read tables.
module tb_bp_update_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [9:0]  bht_raddr;
   logic [5:0]  bht_rdata;
   logic [5:0]  pht_raddr;
   logic [1:0]  pht_rdata;
   logic        bht_we;
   logic [9:0]  bht_waddr;
   logic [5:0]  bht_wdata;
   logic        pht_we;
   logic [5:0]  pht_waddr;
   logic [1:0]  pht_wdata;
   logic        init_busy;
   logic        upd_drop;
   logic [15:0] drop_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   logic [5:0] bht_mem [1024];
   logic [1:0] pht_mem [64];

   bp_update_ctrl #(
      .BHT_DEPTH  (10),
      .PHT_DEPTH  (6),
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .upd_valid (upd_valid),
      .upd_pc    (upd_pc),
      .upd_taken (upd_taken),
      .bht_raddr (bht_raddr),
      .bht_rdata (bht_rdata),
      .pht_raddr (pht_raddr),
      .pht_rdata (pht_rdata),
      .bht_we    (bht_we),
      .bht_waddr (bht_waddr),
      .bht_wdata (bht_wdata),
      .pht_we    (pht_we),
      .pht_waddr (pht_waddr),
      .pht_wdata (pht_wdata),
      .init_busy (init_busy),
      .upd_drop  (upd_drop),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   // Table RAMs: read data valid the cycle after the address
   always @(posedge clk) begin
      if (bht_we) bht_mem[bht_waddr] <= bht_wdata;
      if (pht_we) pht_mem[pht_waddr] <= pht_wdata;
      bht_rdata <= bht_mem[bht_raddr];
      pht_rdata <= pht_mem[pht_raddr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Release reset at a falling edge and follow the whole sweep, with
   // upd_valid held high throughout so it must be ignored.
   task automatic run_init(input logic [31:0] pc);
      int nb = 0;
      int np = 0;
      int aerr = 0;
      int perr = 0;
      int drops = 0;
      bit done = 1'b0;
      rst       = 1'b0;
      upd_valid = 1'b1;
      upd_pc    = pc;
      upd_taken = 1'b1;
      for (int c = 0; c < 1100 && !done; c++) begin
         #1;
         if (!init_busy) begin
            done      = 1'b1;
            upd_valid = 1'b0;
            check("init_we_after_sweep", {31'd0, bht_we}, 32'd0);
         end else begin
            if (bht_we) begin
               if (bht_waddr != nb[9:0] || bht_wdata != 6'd0) aerr++;
               nb++;
            end else begin
               aerr++;
            end
            if (pht_we) begin
               if (pht_waddr != np[5:0] || pht_wdata != 2'b10 || np != nb - 1) perr++;
               np++;
            end
            if (upd_drop) drops++;
            @(negedge clk);
         end
      end
      upd_valid = 1'b0;
      check("init_done", {31'd0, done}, 32'd1);
      check("init_bht_writes", nb, 1024);
      check("init_bht_addr_data_err", aerr, 0);
      check("init_pht_writes", np, 64);
      check("init_pht_addr_data_err", perr, 0);
      check("init_drop_pulses", drops, 0);
   endtask

   // Count any table write over a window where nothing should be queued
   task automatic expect_quiet(input string tag);
      int nw = 0;
      repeat (8) begin
         @(negedge clk);
         if (bht_we || pht_we) nw++;
      end
      check(tag, nw, 0);
      check({tag, "_drop_cnt"}, {16'd0, drop_cnt}, 32'd0);
   endtask

   int burst_idx [8] = '{17, 18, 19, 20, 21, 22, 23, 24};
   int burst_tk  [8] = '{1, 0, 1, 1, 0, 1, 0, 1};
   int exp_idx   [7] = '{17, 18, 19, 20, 21, 22, 24};
   int exp_tk    [7] = '{1, 0, 1, 1, 0, 1, 1};
   int exp_ctr   [7] = '{1, 0, 1, 2, 1, 2, 3};

   initial begin
      int got_a [8];
      int got_d [8];
      int got_p [8];
      int got_pa [8];
      int nwr;
      int ndrop;
      int drop_at;

      rst       = 1'b1;
      upd_valid = 1'b0;
      upd_pc    = '0;
      upd_taken = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_bht_we", {31'd0, bht_we}, 32'd0);
      check("rst_pht_we", {31'd0, pht_we}, 32'd0);
      check("rst_upd_drop", {31'd0, upd_drop}, 32'd0);
      check("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
      check("rst_init_busy", {31'd0, init_busy}, 32'd1);

      // Sweep, with updates offered during INIT
      run_init(32'h0040_0040);
      expect_quiet("init_upd_ignored");

      // Single taken update at pc 0x00400010 -> BHT index 4
      upd_valid = 1'b1;
      upd_pc    = 32'h0040_0010;
      upd_taken = 1'b1;
      @(negedge clk);
      upd_valid = 1'b0;
      check("t1_bht_raddr", {22'd0, bht_raddr}, 32'd4);
      @(negedge clk);
      check("t1_no_write_in_bht_read", {31'd0, bht_we}, 32'd0);
      @(negedge clk);
      check("t1_bht_we", {31'd0, bht_we}, 32'd1);
      check("t1_bht_waddr", {22'd0, bht_waddr}, 32'd4);
      check("t1_bht_wdata", {26'd0, bht_wdata}, 32'h01);
      check("t1_pht_we", {31'd0, pht_we}, 32'd1);
      check("t1_pht_waddr", {26'd0, pht_waddr}, 32'd0);
      check("t1_pht_wdata", {30'd0, pht_wdata}, 32'h3);

      // Reset while an update is in its BHT-read cycle, another queued behind it
      @(negedge clk);
      upd_valid = 1'b1;
      upd_pc    = 32'h0040_0078;
      upd_taken = 1'b1;
      @(negedge clk);
      check("abort_bht_raddr", {22'd0, bht_raddr}, 32'd30);
      upd_pc = 32'h0040_007C;
      @(negedge clk);
      upd_valid = 1'b0;
      rst       = 1'b1;
      #1;
      check("abort_bht_we_c0", {31'd0, bht_we}, 32'd0);
      check("abort_pht_we_c0", {31'd0, pht_we}, 32'd0);
      check("abort_init_busy", {31'd0, init_busy}, 32'd1);
      @(negedge clk);
      check("abort_bht_we_c1", {31'd0, bht_we}, 32'd0);
      check("abort_pht_we_c1", {31'd0, pht_we}, 32'd0);
      run_init(32'h0);
      expect_quiet("abort_fifo_flushed");

      // Two back-to-back not-taken updates at pc 0x00400020 (index 8), bhr 0
      upd_valid = 1'b1;
      upd_pc    = 32'h0040_0020;
      upd_taken = 1'b0;
      @(negedge clk);
      @(negedge clk);
      upd_valid = 1'b0;
      @(negedge clk);
      check("nt1_bht_waddr", {22'd0, bht_waddr}, 32'd8);
      check("nt1_bht_wdata", {26'd0, bht_wdata}, 32'd0);
      check("nt1_pht_waddr", {26'd0, pht_waddr}, 32'd0);
      check("nt1_pht_wdata", {30'd0, pht_wdata}, 32'h1);
      @(negedge clk);
      check("nt2_bht_raddr", {22'd0, bht_raddr}, 32'd8);
      @(negedge clk);
      @(negedge clk);
      check("nt2_bht_we", {31'd0, bht_we}, 32'd1);
      check("nt2_bht_wdata", {26'd0, bht_wdata}, 32'd0);
      check("nt2_pht_waddr", {26'd0, pht_waddr}, 32'd0);
      check("nt2_pht_wdata", {30'd0, pht_wdata}, 32'h0);

      // Burst of 8 consecutive updates from IDLE; the 7th must be dropped
      @(negedge clk);
      nwr     = 0;
      ndrop   = 0;
      drop_at = -1;
      for (int c = 0; c < 30; c++) begin
         if (bht_we) begin
            if (nwr < 8) begin
               got_a[nwr]  = int'(bht_waddr);
               got_d[nwr]  = int'(bht_wdata);
               got_p[nwr]  = pht_we ? int'(pht_wdata) : -1;
               got_pa[nwr] = int'(pht_waddr);
            end
            nwr++;
         end
         if (upd_drop) begin
            ndrop++;
            drop_at = c;
         end
         if (c < 8) begin
            upd_valid = 1'b1;
            upd_pc    = 32'h0040_0000 | (32'(burst_idx[c]) << 2);
            upd_taken = burst_tk[c][0];
         end else begin
            upd_valid = 1'b0;
         end
         @(negedge clk);
      end
      check("burst_writes", nwr, 7);
      check("burst_drop_pulses", ndrop, 1);
      check("burst_drop_cycle", drop_at, 7);
      check("burst_drop_cnt", {16'd0, drop_cnt}, 32'd1);
      for (int k = 0; k < 7; k++) begin
         if (k < nwr) begin
            check($sformatf("burst%0d_bht_waddr", k), got_a[k], exp_idx[k]);
            check($sformatf("burst%0d_bht_wdata", k), got_d[k], exp_tk[k]);
            check($sformatf("burst%0d_pht_waddr", k), got_pa[k], 0);
            check($sformatf("burst%0d_pht_wdata", k), got_p[k], exp_ctr[k]);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
